// File: rtl/sd_photo_seq_reader.sv
// Sector-read sequencer for a run of raw RGB565 photos stored back to back on the SD card.
// Drives the SD controller's read request port and the SDRAM frame-buffer address reload.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; start also clears the sticky errors
// ISSUE   | one-cycle rd_start_en for the current sector address
// WAIT_HI | waiting for the controller to accept (rd_busy high), with timeout
// WAIT_LO | counting rd_val_en strobes until rd_busy falls
// DONE    | one-cycle frame_done; decide between HOLD and IDLE
// HOLD    | inter-frame delay in loop mode; stop aborts straight to IDLE
module sd_photo_seq_reader #(
  parameter logic [31:0] BASE_ADDR     = 32'd8256,
  parameter int          PHOTO_SECTORS = 1200,
  parameter logic [31:0] PHOTO_STRIDE  = 32'd1200,
  parameter int          NUM_PHOTOS    = 4,
  parameter int          WORDS_PER_SEC = 256,
  parameter logic [31:0] HOLD_CYCLES   = 32'd250_000_000,
  parameter int          BUSY_TIMEOUT  = 1024,
  localparam int         PW            = (NUM_PHOTOS > 1) ? $clog2(NUM_PHOTOS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          loop_en,
  input  logic          stop,
  input  logic          rd_busy,
  input  logic          rd_val_en,
  output logic          rd_start_en,
  output logic [31:0]   rd_sec_addr,
  output logic          frame_start,
  output logic          frame_done,
  output logic [PW-1:0] photo_idx,
  output logic          busy,
  output logic          err_words,
  output logic          err_timeout
);

  localparam int SW = (PHOTO_SECTORS > 1) ? $clog2(PHOTO_SECTORS) : 1;
  // One spare code above WORDS_PER_SEC so an overlong sector cannot alias to a good count.
  localparam int WW = $clog2(WORDS_PER_SEC + 2);
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [SW-1:0] SEC_LAST   = SW'(PHOTO_SECTORS - 1);
  localparam logic [PW-1:0] PHOTO_LAST = PW'(NUM_PHOTOS - 1);
  localparam logic [WW-1:0] WORDS_EXP  = WW'(WORDS_PER_SEC);
  localparam logic [WW-1:0] WORDS_MAX  = '1;
  localparam logic [TW-1:0] TMO_LOAD   = TW'(BUSY_TIMEOUT - 1);
  localparam logic [31:0]   HOLD_LOAD  = HOLD_CYCLES - 32'd1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;

  logic [2:0]    state;
  logic [SW-1:0] sec_cnt;
  logic [31:0]   photo_base;
  logic [WW-1:0] word_cnt;
  logic [WW-1:0] word_next;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   hold_cnt;

  // Includes a strobe landing on the same cycle rd_busy falls.
  always_comb begin
    word_next = word_cnt;
    if (rd_val_en && (word_cnt != WORDS_MAX)) word_next = word_cnt + WW'(1);
  end

  assign rd_start_en = (state == S_ISSUE);
  assign frame_done  = (state == S_DONE);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      photo_idx   <= '0;
      sec_cnt     <= '0;
      photo_base  <= BASE_ADDR;
      rd_sec_addr <= BASE_ADDR;
      word_cnt    <= '0;
      tmo_cnt     <= '0;
      hold_cnt    <= '0;
      frame_start <= 1'b0;
      err_words   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err_words   <= 1'b0;
            err_timeout <= 1'b0;
            photo_idx   <= '0;
            sec_cnt     <= '0;
            photo_base  <= BASE_ADDR;
            rd_sec_addr <= BASE_ADDR;
            word_cnt    <= '0;
            frame_start <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt <= TMO_LOAD;
          state   <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (rd_busy) begin
            state <= S_WAIT_LO;
          end else if (tmo_cnt == '0) begin
            // Retry the same sector; rd_sec_addr is left untouched.
            err_timeout <= 1'b1;
            state       <= S_ISSUE;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        S_WAIT_LO: begin
          if (!rd_busy) begin
            if (word_next != WORDS_EXP) err_words <= 1'b1;
            word_cnt <= '0;
            if (sec_cnt == SEC_LAST) begin
              state <= S_DONE;
            end else begin
              sec_cnt     <= sec_cnt + SW'(1);
              rd_sec_addr <= rd_sec_addr + 32'd1;
              state       <= S_ISSUE;
            end
          end else begin
            word_cnt <= word_next;
          end
        end
        S_DONE: begin
          if (loop_en && !stop) begin
            hold_cnt <= HOLD_LOAD;
            state    <= S_HOLD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (stop) begin
            state <= S_IDLE;
          end else if (hold_cnt == '0) begin
            if (photo_idx == PHOTO_LAST) begin
              photo_idx   <= '0;
              photo_base  <= BASE_ADDR;
              rd_sec_addr <= BASE_ADDR;
            end else begin
              photo_idx   <= photo_idx + PW'(1);
              photo_base  <= photo_base + PHOTO_STRIDE;
              rd_sec_addr <= photo_base + PHOTO_STRIDE;
            end
            sec_cnt     <= '0;
            frame_start <= 1'b1;
            state       <= S_ISSUE;
          end else begin
            hold_cnt <= hold_cnt - 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_photo_seq_reader.sv
// Directed bench for sd_photo_seq_reader with a small SD-controller responder model.
module tb_sd_photo_seq_reader;

  localparam logic [31:0] BASE   = 32'h2000;
  localparam logic [31:0] STRIDE = 32'h100;

  logic        clk = 1'b0;
  logic        rst, start, loop_en, stop, rd_busy, rd_val_en;
  logic        rd_start_en, frame_start, frame_done, busy, err_words, err_timeout;
  logic [31:0] rd_sec_addr;
  logic [1:0]  photo_idx;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int overlap  = 0;
  int ignore_cnt = 0;
  logic [31:0] short_addr = 32'hFFFF_FFFF;

  logic [31:0] addr_q[$];
  logic [31:0] start_addr_q[$];
  int          stamp_q[$];
  int          fs_q[$];
  int          fd_q[$];
  int          idle_q[$];
  logic [1:0]  pidx_q[$];
  logic        ew_q[$];
  logic        et_q[$];

  sd_photo_seq_reader #(
    .BASE_ADDR(BASE), .PHOTO_SECTORS(4), .PHOTO_STRIDE(STRIDE), .NUM_PHOTOS(3),
    .WORDS_PER_SEC(8), .HOLD_CYCLES(32'd10), .BUSY_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .stop(stop),
    .rd_busy(rd_busy), .rd_val_en(rd_val_en), .rd_start_en(rd_start_en),
    .rd_sec_addr(rd_sec_addr), .frame_start(frame_start), .frame_done(frame_done),
    .photo_idx(photo_idx), .busy(busy), .err_words(err_words), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // SD controller: busy two cycles after a request, then 8 strobes (7 on short_addr), then idle.
  initial begin
    int n;
    rd_busy   = 1'b0;
    rd_val_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_start_en === 1'b1) begin
        if (ignore_cnt > 0) begin
          ignore_cnt--;
        end else begin
          n = (rd_sec_addr == short_addr) ? 7 : 8;
          repeat (2) @(negedge clk);
          rd_busy = 1'b1;
          repeat (n) begin
            @(negedge clk);
            rd_val_en = 1'b1;
          end
          @(negedge clk);
          rd_val_en = 1'b0;
          rd_busy   = 1'b0;
        end
      end
    end
  end

  // Event recorder, sampled away from the active edge.
  initial begin
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_start_en === 1'b1) begin
        addr_q.push_back(rd_sec_addr);
        stamp_q.push_back(cyc);
        ew_q.push_back(err_words);
        et_q.push_back(err_timeout);
        if (frame_start === 1'b1) start_addr_q.push_back(rd_sec_addr);
      end
      if (frame_start === 1'b1) begin
        fs_q.push_back(cyc);
        pidx_q.push_back(photo_idx);
      end
      if (frame_done === 1'b1) fd_q.push_back(cyc);
      if (frame_start === 1'b1 && frame_done === 1'b1) overlap++;
      if (prev_busy === 1'b1 && busy === 1'b0) idle_q.push_back(cyc);
      prev_busy = busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    addr_q.delete(); start_addr_q.delete(); stamp_q.delete(); fs_q.delete();
    fd_q.delete(); idle_q.delete(); pidx_q.delete(); ew_q.delete(); et_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_start_en"}, rd_start_en, 1'b0);
    chk({tag, "_frame_start"}, frame_start, 1'b0);
    chk({tag, "_frame_done"},  frame_done,  1'b0);
    chk({tag, "_busy"},        busy,        1'b0);
    chk({tag, "_err_words"},   err_words,   1'b0);
    chk({tag, "_err_timeout"}, err_timeout, 1'b0);
    chk({tag, "_photo_idx"},   photo_idx,   2'd0);
    chk({tag, "_rd_sec_addr"}, rd_sec_addr, BASE);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; loop_en = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single photo, loop off
    clear_q();
    pulse_start();
    wait_idle("basic_idle", 500);
    chk("basic_fs_count", fs_q.size(), 1);
    chk("basic_fd_count", fd_q.size(), 1);
    chk("basic_req_count", addr_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("basic_addr%0d", i), addr_q[i], BASE + 32'(i));
    chk("basic_err_words", err_words, 1'b0);
    chk("basic_err_timeout", err_timeout, 1'b0);
    chk("basic_idle_after_done", idle_q[0], fd_q[0] + 1);

    // Loop mode over four frames, then stop during HOLD
    clear_q();
    loop_en = 1'b1;
    pulse_start();
    k = 0;
    while (fd_q.size() < 4 && k < 2000) begin @(negedge clk); k++; end
    chk("loop_four_frames", fd_q.size(), 4);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    chk("hold_stop_idle", busy, 1'b0);
    stop = 1'b0; loop_en = 1'b0;
    repeat (15) @(negedge clk);
    chk("hold_stop_no_fs", fs_q.size(), 4);
    chk("loop_pidx0", pidx_q[0], 2'd0);
    chk("loop_pidx1", pidx_q[1], 2'd1);
    chk("loop_pidx2", pidx_q[2], 2'd2);
    chk("loop_pidx3", pidx_q[3], 2'd0);
    chk("loop_addr0", start_addr_q[0], 32'h2000);
    chk("loop_addr1", start_addr_q[1], 32'h2100);
    chk("loop_addr2", start_addr_q[2], 32'h2200);
    chk("loop_addr3", start_addr_q[3], 32'h2000);
    // Ten HOLD cycles sit strictly between frame_done and the next frame_start.
    for (int i = 0; i < 3; i++) chk($sformatf("loop_gap%0d", i), fs_q[i+1] - fd_q[i], 11);
    chk("fs_fd_overlap", overlap, 0);

    // Stop mid-photo in loop mode: the photo still completes, no HOLD
    clear_q();
    loop_en = 1'b1;
    pulse_start();
    k = 0;
    while (addr_q.size() < 2 && k < 200) begin @(negedge clk); k++; end
    stop = 1'b1;
    wait_idle("stop_mid_idle", 500);
    stop = 1'b0; loop_en = 1'b0;
    chk("stop_mid_req_count", addr_q.size(), 4);
    chk("stop_mid_last_addr", addr_q[3], 32'h2003);
    chk("stop_mid_fd_count", fd_q.size(), 1);
    chk("stop_mid_no_hold", idle_q[0], fd_q[0] + 1);

    // Start and stop in the same IDLE cycle: start wins
    clear_q();
    loop_en = 1'b1;
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle("start_stop_idle", 500);
    stop = 1'b0; loop_en = 1'b0;
    chk("start_stop_req_count", addr_q.size(), 4);
    chk("start_stop_fd_count", fd_q.size(), 1);

    // Short sector 2 sets err_words, which stays set until the next start
    clear_q();
    short_addr = 32'h2002;
    pulse_start();
    wait_idle("words_idle", 500);
    short_addr = 32'hFFFF_FFFF;
    chk("words_req_count", addr_q.size(), 4);
    chk("words_err_before_sec2", ew_q[2], 1'b0);
    chk("words_err_after_sec2", ew_q[3], 1'b1);
    chk("words_err_sticky", err_words, 1'b1);
    clear_q();
    pulse_start();
    chk("words_err_cleared", err_words, 1'b0);
    wait_idle("words_clean_idle", 500);
    chk("words_err_clean_run", err_words, 1'b0);

    // First request ignored: timeout, then a retry at the same address
    clear_q();
    ignore_cnt = 1;
    pulse_start();
    wait_idle("tmo_idle", 800);
    chk("tmo_req_count", addr_q.size(), 5);
    chk("tmo_first_addr", addr_q[0], 32'h2000);
    chk("tmo_retry_addr", addr_q[1], 32'h2000);
    chk("tmo_retry_gap", stamp_q[1] - stamp_q[0], 17);
    chk("tmo_err_before", et_q[0], 1'b0);
    chk("tmo_err_at_retry", et_q[1], 1'b1);
    chk("tmo_err_sticky", err_timeout, 1'b1);
    chk("tmo_last_addr", addr_q[4], 32'h2003);

    // Reset while WAIT_LO is collecting sector 1, then restart from the top
    clear_q();
    pulse_start();
    k = 0;
    while (!(addr_q.size() >= 2 && rd_busy === 1'b1) && k < 200) begin @(negedge clk); k++; end
    chk("rst_mid_reached", rd_busy, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    k = 0;
    while (rd_busy !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk("rst_mid_no_req", rd_start_en, 1'b0);
    clear_q();
    pulse_start();
    wait_idle("rst_restart_idle", 500);
    chk("rst_restart_addr0", addr_q[0], 32'h2000);
    chk("rst_restart_count", addr_q.size(), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_photo_seq_reader.md
Name: sd_photo_seq_reader

Overview:
Parametrised multi-photo successor to the single-image SD reader. It issues sector-read requests to the SD controller's user read interface for one or more raw RGB565 images stored contiguously on the card. Supports single-shot and looped slideshow modes, a programmable hold time between frames, and per-sector word-count checking. Sits between the SD controller (rd_start_en/rd_sec_addr/rd_busy/rd_val_en) and the SDRAM frame-buffer write port, whose address reset it drives via frame_start.

Parameters:
BASE_ADDR, 32'd8256, first sector of photo 0
PHOTO_SECTORS, 1200, sectors per photo (640x480x2 B / 512), >=1
PHOTO_STRIDE, 32'd1200, sector distance between consecutive photos, >=PHOTO_SECTORS
NUM_PHOTOS, 4, photos in the sequence, >=1
WORDS_PER_SEC, 256, 16-bit words expected per sector
HOLD_CYCLES, 32'd250_000_000, clk cycles between frames in loop mode (5 s at 50 MHz), >=1
BUSY_TIMEOUT, 1024, cycles to wait for rd_busy to rise after a request

Ports:
clk  input  1  block clock (same domain as the SD controller)
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; starts the sequence at photo 0
loop_en  input  1  0 = read one photo then stop; 1 = cycle through photos continuously
stop  input  1  level; finish the current photo, then go to IDLE
rd_busy  input  1  SD controller read busy
rd_val_en  input  1  SD controller read-data valid strobe
rd_start_en  output  1  one-cycle read request pulse
rd_sec_addr  output  32  sector address, valid while rd_start_en is high and held afterwards
frame_start  output  1  one-cycle pulse before the first sector of each photo (SDRAM write-address reload)
frame_done  output  1  one-cycle pulse after the last sector of a photo completes
photo_idx  output  clog2(NUM_PHOTOS) (min 1)  index of the photo being read
busy  output  1  high in every state except IDLE
err_words  output  1  sticky; set when a sector delivers a word count other than WORDS_PER_SEC
err_timeout  output  1  sticky; set on a BUSY_TIMEOUT expiry

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE. Outputs rd_start_en, frame_start, frame_done, busy, err_words, err_timeout, photo_idx = 0; rd_sec_addr = BASE_ADDR. All counters are cleared. Reset overrides everything, including mid-sector operation.
- States:
  - IDLE: on start=1, set photo_idx=0 and sec_cnt=0, pulse frame_start for 1 cycle, go to ISSUE. While in IDLE, start clears both sticky errors.
  - ISSUE: drive rd_start_en=1 for exactly 1 cycle with rd_sec_addr = BASE_ADDR + photo_idx*PHOTO_STRIDE + sec_cnt (32-bit modulo 2^32). Go to WAIT_HI.
  - WAIT_HI: wait for rd_busy=1, then go to WAIT_LO. If rd_busy stays low for BUSY_TIMEOUT cycles: set err_timeout, go to ISSUE with the same address (unlimited retries).
  - WAIT_LO: count rd_val_en pulses (counter saturates at its maximum). On the cycle rd_busy=0:
    - if word count != WORDS_PER_SEC, set err_words;
    - clear the word counter;
    - if sec_cnt == PHOTO_SECTORS-1, go to DONE; otherwise sec_cnt++ and go to ISSUE.
  - DONE: pulse frame_done for 1 cycle.
    - If loop_en=1 and stop=0: go to HOLD.
    - Otherwise go to IDLE.
  - HOLD: count HOLD_CYCLES cycles. At the end, photo_idx = (photo_idx==NUM_PHOTOS-1) ? 0 : photo_idx+1; sec_cnt=0; pulse frame_start; go to ISSUE. If stop=1 during HOLD, go to IDLE immediately.
- Minimum gap between consecutive rd_start_en pulses is 3 cycles: ISSUE, then WAIT_HI seeing busy, then WAIT_LO seeing not-busy.
- rd_val_en is counted only in WAIT_LO; in any other state it is ignored.
- start is ignored outside IDLE.
- stop asserted mid-photo takes effect only at DONE/HOLD; a photo is never truncated.
- A start and a stop arriving in the same IDLE cycle: start wins; stop is then sampled at DONE.
- frame_start and frame_done are never high in the same cycle.

Test Plan:
- Basic read. Params PHOTO_SECTORS=4, NUM_PHOTOS=3, BASE_ADDR=0x2000, STRIDE=0x100, WORDS_PER_SEC=8, HOLD_CYCLES=10. Controller model: busy 2 cycles after request, 8 strobes, then low. start, loop_en=0 -> frame_start once; rd_sec_addr 0x2000, 0x2001, 0x2002, 0x2003; frame_done once; busy drops; no errors.
- Loop mode, same params, loop_en=1. Run 4 frames -> photo_idx 0,1,2,0; first addresses 0x2000, 0x2100, 0x2200, 0x2000. Exactly 10 cycles between each frame_done and the next frame_start.
- Word error. Model delivers 7 strobes on sector 2 -> err_words sets after that sector and stays set. Sequencing continues; the next start from IDLE clears it.
- Timeout. BUSY_TIMEOUT=16; model ignores the first request -> err_timeout set at cycle 16. rd_start_en re-pulses with the same address 0x2000 and the read completes normally.
- Stop handling. Assert stop during sector 1 of photo 0 in loop mode -> all 4 sectors are still read, frame_done pulses, then IDLE with no HOLD. Separately, stop during HOLD -> IDLE on the next cycle with no frame_start.
- Reset in WAIT_LO mid-sector -> next cycle all outputs are at reset values. A subsequent start restarts at 0x2000.
